arb_mux2_stream: RTL and testbench

- Two-input streaming arbiter with a registered 2:1 data path.
- Each input presents packets on a valid/ready/last interface. The block grants one input at a time with round-robin priority and holds the grant for a whole packet.
- The granted beat is forwarded through a single output register, so the 2:1 selection and the grant decision occur in the same cycle.
- Sits downstream of two producers and upstream of a single consumer.

---
 rtl/arb_mux2_stream_pkg.sv | 16 +
 rtl/arb_mux2_stream_out_reg_slice.sv | 63 ++++++
 rtl/arb_mux2_stream.sv | 121 ++++++++++++
 tb/tb_arb_mux2_stream.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux2_stream_pkg.sv
// Shared types and constants for the two-input streaming arbiter.
//   state_e : arbiter FSM states (idle / locked on a packet)
//   CH0/CH1 : channel index constants used for grant and out_sel
package arb_mux2_stream_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage : arb_mux2_stream_pkg

// File: rtl/arb_mux2_stream_out_reg_slice.sv
// Output register slice: 2:1 data/last select feeding a load/drain register.
//   clk, rst           : clock, synchronous active-high reset
//   load_i, sel_i      : load the beat selected by sel_i this cycle
//   d0_i/l0_i, d1_i/l1_i : channel 0/1 data and last flag
//   ready_i            : downstream accepts the held beat
//   valid_o/data_o/last_o/sel_o : registered beat and its source channel
//   can_load_c         : register free this cycle (empty or draining)
module arb_mux2_stream_out_reg_slice
  import arb_mux2_stream_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         sel_i,
  input  logic [W-1:0] d0_i,
  input  logic         l0_i,
  input  logic [W-1:0] d1_i,
  input  logic         l1_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         last_o,
  output logic         sel_o,
  output logic         can_load_c
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         last_q;
  logic         sel_q;
  logic [W-1:0] mux_data;
  logic         mux_last;

  // 2:1 selection of the granted channel
  assign mux_data   = (sel_i == CH1) ? d1_i : d0_i;
  assign mux_last   = (sel_i == CH1) ? l1_i : l0_i;
  assign can_load_c = !valid_q || ready_i;

  // A load takes precedence over a drain so load+drain keeps full throughput
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= CH0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= mux_data;
      last_q  <= mux_last;
      sel_q   <= sel_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign sel_o   = sel_q;

endmodule : arb_mux2_stream_out_reg_slice

// File: rtl/arb_mux2_stream.sv
// Two-input round-robin packet arbiter with a registered 2:1 output.
//   clk, rst                         : clock, synchronous active-high reset
//   in0_valid/data/last, in0_ready   : channel 0 stream (ready combinational)
//   in1_valid/data/last, in1_ready   : channel 1 stream (ready combinational)
//   out_valid/data/last/sel          : registered output beat and its source
//   out_ready                        : consumer accepts the output beat
module arb_mux2_stream
  import arb_mux2_stream_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_valid,
  input  logic [W-1:0] in0_data,
  input  logic         in0_last,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [W-1:0] in1_data,
  input  logic         in1_last,
  output logic         in1_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         out_sel,
  input  logic         out_ready
);

  state_e state_q, state_d;
  logic   lock_ch_q, lock_ch_d;
  logic   prio_q, prio_d;
  logic   gnt_vld;
  logic   gnt_ch;
  logic   gnt_last;
  logic   accept;
  logic   can_load;

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lock_ch_q <= CH0;
      prio_q    <= CH0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      prio_q    <= prio_d;
    end
  end

  // Grant, ready and next-state logic
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    prio_d    = prio_q;
    gnt_vld   = 1'b0;
    gnt_ch    = prio_q;
    in0_ready = 1'b0;
    in1_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Ready looks only at the other channel's valid, so it is high exactly
        // when this channel would win if it presented a beat.
        in0_ready = can_load && (!in1_valid || (prio_q == CH0));
        in1_ready = can_load && (!in0_valid || (prio_q == CH1));
        if (in0_valid && in1_valid) begin
          gnt_vld = 1'b1;
          gnt_ch  = prio_q;
        end else if (in0_valid) begin
          gnt_vld = 1'b1;
          gnt_ch  = CH0;
        end else if (in1_valid) begin
          gnt_vld = 1'b1;
          gnt_ch  = CH1;
        end
      end
      ST_LOCK: begin
        gnt_ch    = lock_ch_q;
        gnt_vld   = (lock_ch_q == CH1) ? in1_valid : in0_valid;
        in0_ready = can_load && (lock_ch_q == CH0);
        in1_ready = can_load && (lock_ch_q == CH1);
      end
      default: state_d = ST_IDLE;
    endcase

    gnt_last = (gnt_ch == CH1) ? in1_last : in0_last;
    accept   = gnt_vld && can_load;

    // Priority rotates only when a packet completes
    if (accept) begin
      if (gnt_last) begin
        state_d = ST_IDLE;
        prio_d  = ~gnt_ch;
      end else begin
        state_d   = ST_LOCK;
        lock_ch_d = gnt_ch;
      end
    end
  end

  arb_mux2_stream_out_reg_slice #(
    .W (W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .sel_i      (gnt_ch),
    .d0_i       (in0_data),
    .l0_i       (in0_last),
    .d1_i       (in1_data),
    .l1_i       (in1_last),
    .ready_i    (out_ready),
    .valid_o    (out_valid),
    .data_o     (out_data),
    .last_o     (out_last),
    .sel_o      (out_sel),
    .can_load_c (can_load)
  );

endmodule : arb_mux2_stream

// File: tb/tb_arb_mux2_stream.sv
// Directed and randomised-stream checks for arb_mux2_stream.
module tb_arb_mux2_stream;

  localparam int unsigned W = 8;
  localparam int unsigned N = 150;

  logic         clk = 1'b0;
  logic         rst;
  logic         in0_valid, in0_last, in0_ready;
  logic [W-1:0] in0_data;
  logic         in1_valid, in1_last, in1_ready;
  logic [W-1:0] in1_data;
  logic         out_valid, out_last, out_sel, out_ready;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_d [2][N];
  logic         exp_l [2][N];

  always #5 clk = ~clk;

  arb_mux2_stream #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic s, input logic l);
    chk({tag, "_valid"}, 32'(out_valid), 32'h1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_sel"},   32'(out_sel),   32'(s));
    chk({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, "_rdy0"}, 32'(in0_ready), 32'(r0));
    chk({tag, "_rdy1"}, 32'(in1_ready), 32'(r1));
  endtask

  initial begin
    int  idx [2];
    int  oidx [2];
    bit  vld [2];
    bit  acc [2];
    bit  in_pkt;
    bit  cur_ch;
    int  cyc;

    rst = 1'b1; out_ready = 1'b0;
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  32'(out_data),  32'h0);
    chk("rst_sel",   32'(out_sel),   32'h0);
    chk("rst_last",  32'(out_last),  32'h0);

    // Single-beat packets on both channels: round-robin alternation
    rst = 1'b0; out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'hA0; in0_last = 1'b1;
    in1_valid = 1'b1; in1_data = 8'hB1; in1_last = 1'b1;
    chk_rdy("tie0", 1'b1, 1'b0);
    tick(); chk_out("rr0", 8'hA0, 1'b0, 1'b1);
    tick(); chk_out("rr1", 8'hB1, 1'b1, 1'b1);
    tick(); chk_out("rr2", 8'hA0, 1'b0, 1'b1);
    tick(); chk_out("rr3", 8'hB1, 1'b1, 1'b1);
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick(); chk("rr_drain", 32'(out_valid), 32'h0);

    // Packet lock on channel 0 while channel 1 waits
    in0_valid = 1'b1; in0_data = 8'h01; in0_last = 1'b0;
    in1_valid = 1'b1; in1_data = 8'h20; in1_last = 1'b1;
    tick(); chk_out("lk1", 8'h01, 1'b0, 1'b0);
    in0_data = 8'h02;
    chk_rdy("lk2", 1'b1, 1'b0);
    tick(); chk_out("lk2", 8'h02, 1'b0, 1'b0);
    in0_data = 8'h03; in0_last = 1'b1;
    chk_rdy("lk3", 1'b1, 1'b0);
    tick(); chk_out("lk3", 8'h03, 1'b0, 1'b1);
    in0_data = 8'h04;
    chk_rdy("lk_rot", 1'b0, 1'b1);
    tick(); chk_out("lk_in1", 8'h20, 1'b1, 1'b1);

    // Backpressure with a beat held in the output register
    in1_valid = 1'b0; out_ready = 1'b0;
    chk_rdy("bp_start", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("bp_hold", 8'h20, 1'b1, 1'b1);
      chk_rdy("bp_hold", 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    chk_rdy("bp_release", 1'b1, 1'b0);
    tick(); chk_out("bp_reload", 8'h04, 1'b0, 1'b1);
    in0_valid = 1'b0;
    tick(); chk("bp_drain", 32'(out_valid), 32'h0);

    // Gap inside a channel-1 lock; channel 0 must not be granted
    in1_valid = 1'b1; in1_data = 8'h10; in1_last = 1'b0;
    in0_valid = 1'b1; in0_data = 8'h30; in0_last = 1'b1;
    chk_rdy("gap_start", 1'b0, 1'b1);
    tick(); chk_out("gap_b0", 8'h10, 1'b1, 1'b0);
    in1_valid = 1'b0;
    chk_rdy("gap_idle0", 1'b0, 1'b1);
    tick(); chk("gap_drain", 32'(out_valid), 32'h0);
    chk_rdy("gap_idle1", 1'b0, 1'b1);
    tick(); chk("gap_empty", 32'(out_valid), 32'h0);
    in1_valid = 1'b1; in1_data = 8'h11; in1_last = 1'b1;
    tick(); chk_out("gap_b1", 8'h11, 1'b1, 1'b1);
    in1_valid = 1'b0;
    tick(); chk_out("gap_in0", 8'h30, 1'b0, 1'b1);
    in0_valid = 1'b0;
    tick(); chk("gap_end", 32'(out_valid), 32'h0);

    // Reset in the middle of a channel-1 packet
    in1_valid = 1'b1; in1_data = 8'h40; in1_last = 1'b0;
    tick(); chk_out("mrst_b0", 8'h40, 1'b1, 1'b0);
    rst = 1'b1; in1_data = 8'h41;
    tick(); chk("mrst_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    in0_valid = 1'b1; in0_data = 8'h50; in0_last = 1'b1;
    in1_data = 8'h42; in1_last = 1'b1;
    chk_rdy("mrst_tie", 1'b1, 1'b0);
    tick(); chk_out("mrst_win", 8'h50, 1'b0, 1'b1);
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick(); chk("mrst_end", 32'(out_valid), 32'h0);

    // Random valid/out_ready streams checked against per-channel expected order
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        exp_d[c][i] = (c == 1) ? (8'h80 | 8'(i & 32'h7f)) : 8'(i & 32'h7f);
        exp_l[c][i] = (i == int'(N) - 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
      end
      idx[c] = 0; oidx[c] = 0; vld[c] = 1'b0; acc[c] = 1'b0;
    end
    in_pkt = 1'b0; cur_ch = 1'b0; cyc = 0;
    while ((oidx[0] < int'(N) || oidx[1] < int'(N)) && cyc < 20000) begin
      for (int c = 0; c < 2; c++) begin
        if (acc[c]) begin idx[c]++; vld[c] = 1'b0; end
        if (!vld[c] && idx[c] < int'(N) && $urandom_range(0, 3) != 0) vld[c] = 1'b1;
      end
      in0_valid = vld[0];
      in0_data  = (idx[0] < int'(N)) ? exp_d[0][idx[0]] : 8'h00;
      in0_last  = (idx[0] < int'(N)) ? exp_l[0][idx[0]] : 1'b0;
      in1_valid = vld[1];
      in1_data  = (idx[1] < int'(N)) ? exp_d[1][idx[1]] : 8'h00;
      in1_last  = (idx[1] < int'(N)) ? exp_l[1][idx[1]] : 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc[0] = in0_valid && in0_ready;
      acc[1] = in1_valid && in1_ready;
      if (out_valid && out_ready) begin
        if (in_pkt) chk("rnd_interleave", 32'(out_sel), 32'(cur_ch));
        if (oidx[out_sel] < int'(N)) begin
          chk("rnd_data", 32'(out_data), 32'(exp_d[out_sel][oidx[out_sel]]));
          chk("rnd_last", 32'(out_last), 32'(exp_l[out_sel][oidx[out_sel]]));
        end else begin
          chk("rnd_extra_beat", 32'(oidx[out_sel]), 32'(N - 1));
        end
        oidx[out_sel]++;
        in_pkt = !out_last;
        cur_ch = out_sel;
      end
      cyc++;
      tick();
    end
    chk("rnd_count0", 32'(oidx[0]), 32'(N));
    chk("rnd_count1", 32'(oidx[1]), 32'(N));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_arb_mux2_stream
